rd_symfn_seq: RTL and testbench
===============================

// Module: rd_symfn_seq
// PURPOSE
//   Sequential, parametrised evaluator for rd-class symmetric functions.
//   Accepts an N_IN-bit vector over a valid/ready handshake and counts its ones CHUNK bits per cycle.
//   Returns the full Hamming weight plus one selectable symmetric-function bit z.
//   Successor to the fixed 8-input combinational NOR-mapped rd84 outputs. Sits between the
//   vector source and the NOR/MAGIC evaluation fabric as a reusable multi-mode unit.
// PARAMETERS
//   N_IN   8                    number of input bits; must be a multiple of CHUNK (elaboration error otherwise)
//   CHUNK  2                    input bits summed per COUNT cycle (1..N_IN)
//   W_CNT  $clog2(N_IN+1)       width of the weight result (derived; not to be overridden)
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request valid
//   in_ready   out  1      unit can accept a request
//   in_data    in   N_IN   input vector
//   in_mode    in   2      0=WEIGHT_BIT, 1=THRESH (>=), 2=EXACT (==), 3=PARITY
//   in_arg     in   W_CNT  bit index (mode 0) or compare value (modes 1, 2); ignored in mode 3
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out_weight out  W_CNT  number of ones in the captured in_data
//   out_z      out  1      selected symmetric-function value
//   busy       out  1      high in COUNT or DONE
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; out_valid=0; out_weight=0; out_z=0; busy=0; accumulator=0.
//   rst_n low at any time (including mid-COUNT or in DONE) clears everything asynchronously.
//   A partial count or an unconsumed result is discarded.
//   FSM: IDLE -> COUNT -> DONE -> IDLE.
//   - IDLE: in_ready=1. On in_valid&in_ready:
//     - capture in_data, in_mode and in_arg;
//     - clear the accumulator and the chunk index;
//     - go to COUNT.
//   - COUNT: in_ready=0. Each cycle:
//     - add popcount(data[idx*CHUNK +: CHUNK]) to the accumulator;
//     - on idx==N_IN/CHUNK-1, go to DONE;
//     - otherwise increment idx.
//   - DONE: out_valid=1. out_weight and out_z are registered and held stable until out_valid&out_ready.
//     The same cycle returns to IDLE, out_valid drops next cycle, and outputs keep their last values.
//   Latency: accept edge at cycle 0. COUNT occupies cycles 1..N_IN/CHUNK. out_valid is high from
//   cycle N_IN/CHUNK+1. Minimum request period is N_IN/CHUNK+2 cycles. There is no overlap;
//   in_ready=0 in COUNT and DONE.
//   z is computed once, on the COUNT->DONE transition, from the final weight w:
//   - mode 0: z = w[arg] if arg < W_CNT, otherwise z = 0.
//   - mode 1: z = (w >= arg). arg=0 gives z=1.
//   - mode 2: z = (w == arg). arg > N_IN gives z=0.
//   - mode 3: z = w[0] (odd parity of in_data).
//   Arithmetic: unsigned. The accumulator is W_CNT bits and cannot overflow (max N_IN).
//   Input changes while not in IDLE are ignored. out_ready in IDLE or COUNT is ignored.
//   If in_valid is held across DONE->IDLE, it is accepted the cycle after the output handshake.
// TESTING (N_IN=8, CHUNK=2 unless noted)
//   1. in_data=8'hFF, mode 0, arg 3, out_ready=1 -> out_valid exactly at cycle 5;
//      out_weight=8, out_z=1; in_ready low cycles 1..5.
//   2. Exhaustive 0x00..0xFF, modes 0..3, every arg 0..15 -> out_weight==$countones(in_data);
//      out_z matches the golden model. Includes mode 2 arg 4 (rd84 weight-4 function).
//   3. in_data=8'h0F, mode 1, arg 5, out_ready=0 for 10 cycles -> out_valid=1,
//      out_weight=4 and out_z=0 held stable; then out_ready=1 -> one handshake, in_ready=1 next cycle.
//   4. Assert rst_n=0 in cycle 2 of COUNT (in_data=8'hAA) -> outputs zero immediately,
//      in_ready=1; next request 8'h01 mode 3 -> out_weight=1, out_z=1, no stale carry-over.
//   5. Edge args: mode 0 arg 9 -> z=0; mode 1 arg 0 with in_data=0 -> z=1;
//      mode 2 arg 15 -> z=0.
//   6. Params N_IN=12, CHUNK=3 and N_IN=8, CHUNK=1 -> latency N_IN/CHUNK+1 (5 and 9);
//      random vectors match the golden popcount model.

Source files
------------

// File: rtl/rd_symfn_seq.sv
// Sequential rd-class symmetric-function evaluator: counts the ones of a captured vector
// CHUNK bits per cycle, then reports the Hamming weight and one selectable function bit.
module rd_symfn_seq #(
  parameter int N_IN  = 8,
  parameter int CHUNK = 2,
  parameter int W_CNT = $clog2(N_IN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [W_CNT-1:0] in_arg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_CNT-1:0] out_weight,
  output logic             out_z,
  output logic             busy
);

  localparam int NCH   = N_IN / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  if ((CHUNK < 1) || (CHUNK > N_IN) || ((N_IN % CHUNK) != 0)) begin : g_bad_param
    $error("rd_symfn_seq: N_IN must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] M_WBIT   = 2'd0;
  localparam logic [1:0] M_THRESH = 2'd1;
  localparam logic [1:0] M_EXACT  = 2'd2;

  function automatic logic [W_CNT-1:0] chunk_pop(input logic [CHUNK-1:0] v);
    logic [W_CNT-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK; i++) begin
      c = c + W_CNT'(v[i]);
    end
    return c;
  endfunction

  // A shift past the top of w yields zero, which covers the out-of-range bit index case.
  function automatic logic sym_fn(input logic [W_CNT-1:0] w, input logic [1:0] mode,
                                  input logic [W_CNT-1:0] arg);
    logic [W_CNT-1:0] sh;
    sh = w >> arg;
    case (mode)
      M_WBIT:   return sh[0];
      M_THRESH: return (w >= arg);
      M_EXACT:  return (w == arg);
      default:  return w[0];
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [N_IN-1:0]  data_q, data_d;
  logic [1:0]       mode_q, mode_d;
  logic [W_CNT-1:0] arg_q, arg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W_CNT-1:0] acc_q, acc_d;
  logic [W_CNT-1:0] weight_q, weight_d;
  logic             z_q, z_d;

  logic [31:0]      shamt;
  logic [N_IN-1:0]  shifted;
  logic [CHUNK-1:0] chunk_v;
  logic             last_chunk;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mode_d     = mode_q;
    arg_d      = arg_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    weight_d   = weight_q;
    z_d        = z_q;
    shamt      = 32'(idx_q) * 32'(CHUNK);
    shifted    = data_q >> shamt;
    chunk_v    = shifted[CHUNK-1:0];
    last_chunk = (idx_q == IDX_W'(NCH - 1));

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_mode;
          arg_d   = in_arg;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        acc_d = acc_q + chunk_pop(chunk_v);
        if (last_chunk) begin
          weight_d = acc_d;
          z_d      = sym_fn(acc_d, mode_q, arg_q);
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      mode_q   <= '0;
      arg_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      weight_q <= '0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      arg_q    <= arg_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      weight_q <= weight_d;
      z_q      <= z_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_weight = weight_q;
  assign out_z      = z_q;

endmodule

// File: tb/tb_rd_symfn_seq.sv
// Scoreboard bench for rd_symfn_seq: main 8/2 instance plus 12/3 and 8/1 instances.
module tb_rd_symfn_seq;

  typedef struct packed {
    logic [3:0] w;
    logic       z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance N_IN=8, CHUNK=2
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_z, busy;
  logic [7:0] in_data = '0;
  logic [1:0] in_mode = '0;
  logic [3:0] in_arg = '0, out_weight;

  rd_symfn_seq #(.N_IN(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_arg(in_arg), .out_valid(out_valid), .out_ready(out_ready),
    .out_weight(out_weight), .out_z(out_z), .busy(busy));

  // N_IN=12, CHUNK=3
  logic        b_valid = 1'b0, b_ready, b_ovalid, b_oready = 1'b1, b_z, b_busy;
  logic [11:0] b_data = '0;
  logic [1:0]  b_mode = '0;
  logic [3:0]  b_arg = '0, b_weight;

  rd_symfn_seq #(.N_IN(12), .CHUNK(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .in_mode(b_mode), .in_arg(b_arg), .out_valid(b_ovalid), .out_ready(b_oready),
    .out_weight(b_weight), .out_z(b_z), .busy(b_busy));

  // N_IN=8, CHUNK=1
  logic       c_valid = 1'b0, c_ready, c_ovalid, c_oready = 1'b1, c_z, c_busy;
  logic [7:0] c_data = '0;
  logic [1:0] c_mode = '0;
  logic [3:0] c_arg = '0, c_weight;

  rd_symfn_seq #(.N_IN(8), .CHUNK(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
    .in_mode(c_mode), .in_arg(c_arg), .out_valid(c_ovalid), .out_ready(c_oready),
    .out_weight(c_weight), .out_z(c_z), .busy(c_busy));

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic zmodel(input int w, input int m, input int a, input int wc);
    case (m)
      0:       return (a < wc) ? w[a] : 1'b0;
      1:       return (w >= a);
      2:       return (w == a);
      default: return w[0];
    endcase
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic [1:0] m, input logic [3:0] a);
    exp_t e;
    int   w;
    w   = $countones(d);
    e.w = 4'(w);
    e.z = zmodel(w, int'(m), int'(a), 4);
    sb.push_back(e);
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [3:0] a,
                      input bit push);
    int n;
    n = 0;
    in_data = d; in_mode = m; in_arg = a; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    if (push) push_exp(d, m, a);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_b(input logic [11:0] d, input logic [1:0] m, input logic [3:0] a);
    int lat, w;
    chk("b_ready", b_ready, 1);
    b_data = d; b_mode = m; b_arg = a; b_valid = 1'b1;
    @(posedge clk);
    #1 b_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b_ovalid && lat < 50);
    w = $countones(d);
    chk("b_latency", lat, 5);
    chk("b_weight", b_weight, w);
    chk("b_z", b_z, zmodel(w, int'(m), int'(a), 4));
    @(posedge clk);
    #1;
  endtask

  task automatic run_c(input logic [7:0] d, input logic [1:0] m, input logic [3:0] a);
    int lat, w;
    chk("c_ready", c_ready, 1);
    c_data = d; c_mode = m; c_arg = a; c_valid = 1'b1;
    @(posedge clk);
    #1 c_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!c_ovalid && lat < 50);
    w = $countones(d);
    chk("c_latency", lat, 9);
    chk("c_weight", c_weight, w);
    chk("c_z", c_z, zmodel(w, int'(m), int'(a), 4));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_weight", out_weight, e.w);
        chk("out_z", out_z, e.z);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_weight", out_weight, 0);
    chk("rst_z", out_z, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_c_busy", c_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // latency and in_ready timing for a single request
    in_data = 8'hFF; in_mode = 2'd0; in_arg = 4'd3; in_valid = 1'b1;
    @(negedge clk);
    chk("t1_ready_idle", in_ready, 1);
    push_exp(8'hFF, 2'd0, 4'd3);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t1_in_ready_low", in_ready, 0);
      chk("t1_out_valid", out_valid, (k == 5) ? 1 : 0);
    end
    @(negedge clk);
    chk("t1_ready_back", in_ready, 1);
    @(posedge clk);
    #1;

    // sweep of all vectors; args rotate through 0..15 per mode
    for (int d = 0; d < 256; d++) begin
      for (int m = 0; m < 4; m++) begin
        send(8'(d), 2'(m), 4'((d + 7 * m) % 16), 1'b1);
      end
      send(8'(d), 2'd2, 4'd4, 1'b1);
    end
    drain();

    // back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    send(8'h0F, 2'd1, 4'd5, 1'b1);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    end
    for (int k = 0; k < 10; k++) begin
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_weight", out_weight, 4);
      chk("t3_hold_z", out_z, 0);
      chk("t3_hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_ready_after", in_ready, 1);
    chk("t3_valid_after", out_valid, 0);
    chk("t3_weight_kept", out_weight, 4);
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of COUNT
    send(8'hAA, 2'd0, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t4_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t4_in_ready", in_ready, 1);
    chk("t4_out_valid", out_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_weight", out_weight, 0);
    chk("t4_z", out_z, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h01, 2'd3, 4'd0, 1'b1);
    drain();

    // edge arguments
    send(8'hFF, 2'd0, 4'd9, 1'b1);
    send(8'h00, 2'd1, 4'd0, 1'b1);
    send(8'hFF, 2'd2, 4'd15, 1'b1);
    send(8'h35, 2'd0, 4'd15, 1'b1);
    drain();

    // other parameter sets
    run_b(12'hFFF, 2'd2, 4'd12);
    run_b(12'h000, 2'd1, 4'd0);
    for (int i = 0; i < 20; i++) begin
      run_b(12'($urandom), 2'($urandom), 4'($urandom));
    end
    run_c(8'hFF, 2'd0, 4'd3);
    for (int i = 0; i < 20; i++) begin
      run_c(8'($urandom), 2'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
